// File: rtl/prewish_input_scanner.sv
// Syncs/debounces button + active-low DIPs; a press captures the DIP mask with a one-cycle o_load.
// Status fetch: STB_I accepted in IDLE, STB_O/DAT_O two edges later; requests while busy are dropped.
module prewish_input_scanner #(
  parameter int DEB_CYCLES = 16,
  parameter int ALIVE_BITS = 22
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  input  logic       i_button,
  input  logic [7:0] i_dip_n,
  output logic [7:0] o_mask,
  output logic       o_load,
  output logic       o_alive
);

  localparam int              CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [8:0]      IN_RST   = 9'h1FE;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SAMPLE = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  // Bit 0 is the button, bits 8:1 the active-low DIPs.
  logic [8:0]          r_sync1;
  logic [8:0]          r_sync2;
  logic [8:0]          r_db;
  logic [CW-1:0]       r_cnt [9];
  logic                r_btn_prev;
  logic [7:0]          r_mask;
  logic                r_load;
  logic [1:0]          r_state;
  logic [7:0]          r_req_mask;
  logic [7:0]          r_dat_o;
  logic                r_stb_o;
  logic [ALIVE_BITS-1:0] r_alive_cnt;

  logic       w_btn_db;
  logic [7:0] w_dip_db;
  logic       w_press;

  assign w_btn_db = r_db[0];
  assign w_dip_db = ~r_db[8:1];
  assign w_press  = w_btn_db & ~r_btn_prev;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_sync1 <= IN_RST;
      r_sync2 <= IN_RST;
    end else begin
      r_sync1 <= {i_dip_n, i_button};
      r_sync2 <= r_sync1;
    end
  end

  // The flip fires on the DEB_CYCLES-th consecutive differing cycle.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_db <= IN_RST;
      for (int i = 0; i < 9; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_db[i]  <= r_sync2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_btn_prev <= 1'b0;
      r_mask     <= 8'h00;
      r_load     <= 1'b0;
    end else begin
      r_btn_prev <= w_btn_db;
      r_load     <= w_press;
      if (w_press) r_mask <= w_dip_db;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state    <= ST_IDLE;
      r_req_mask <= 8'h00;
      r_dat_o    <= 8'h00;
      r_stb_o    <= 1'b0;
    end else begin
      r_stb_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (STB_I) begin
            r_req_mask <= DAT_I;
            r_state    <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          r_dat_o <= {w_dip_db[6:0], w_btn_db} & r_req_mask;
          r_stb_o <= 1'b1;
          r_state <= ST_ACK;
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) r_alive_cnt <= '0;
    else       r_alive_cnt <= r_alive_cnt + 1'b1;
  end

  assign STB_O   = r_stb_o;
  assign DAT_O   = r_dat_o;
  assign o_mask  = r_mask;
  assign o_load  = r_load;
  assign o_alive = r_alive_cnt[ALIVE_BITS-1];

endmodule

// File: tb/tb_prewish_input_scanner.sv
// Scoreboard bench for prewish_input_scanner: status replies and load pulses are queued and popped at output.
module tb_prewish_input_scanner;
  localparam int DEB = 16;
  localparam int AB  = 6;

  logic       CLK_I = 1'b0;
  logic       RST_I;
  logic       STB_I;
  logic [7:0] DAT_I;
  logic       STB_O;
  logic [7:0] DAT_O;
  logic       i_button;
  logic [7:0] i_dip_n;
  logic [7:0] o_mask;
  logic       o_load;
  logic       o_alive;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] q_stb [$];
  logic [7:0] q_load [$];
  logic [AB-1:0] ref_alive;

  prewish_input_scanner #(.DEB_CYCLES(DEB), .ALIVE_BITS(AB)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .DAT_I(DAT_I),
    .STB_O(STB_O), .DAT_O(DAT_O), .i_button(i_button), .i_dip_n(i_dip_n),
    .o_mask(o_mask), .o_load(o_load), .o_alive(o_alive)
  );

  always #5 CLK_I = ~CLK_I;

  always @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) ref_alive <= '0;
    else       ref_alive <= ref_alive + 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK_I);
    #1;
  endtask

  function automatic logic [7:0] stat(input logic [7:0] dip_n, input logic btn, input logic [7:0] m);
    logic [7:0] on;
    on = ~dip_n;
    return {on[6:0], btn} & m;
  endfunction

  // Single request with exact latency checks on STB_O.
  task automatic fetch(input logic [7:0] m);
    logic [7:0] e;
    e = stat(i_dip_n, i_button, m);
    q_stb.push_back(e);
    STB_I = 1'b1;
    DAT_I = m;
    tick(1);
    chk("stb_early", {31'b0, STB_O}, 32'd0);
    chk("alive", {31'b0, o_alive}, {31'b0, ref_alive[AB-1]});
    STB_I = 1'b0;
    tick(1);
    chk("stb_lat", {31'b0, STB_O}, 32'd1);
    chk("dat_lat", {24'b0, DAT_O}, {24'b0, e});
    tick(1);
    chk("stb_len", {31'b0, STB_O}, 32'd0);
    tick(3);
  endtask

  // STB_I held for n edges; each accepted request yields exactly one reply.
  task automatic fetch_hold(input logic [7:0] m, input int n, input int replies);
    for (int k = 0; k < replies; k++) q_stb.push_back(stat(i_dip_n, i_button, m));
    STB_I = 1'b1;
    DAT_I = m;
    tick(n);
    STB_I = 1'b0;
    tick(8);
    chk("hold_q", q_stb.size(), 0);
  endtask

  always @(negedge CLK_I) begin
    if (STB_O) begin
      if (q_stb.size() == 0) chk("stb_extra", {31'b0, STB_O}, 32'd0);
      else                   chk("dat_o", {24'b0, DAT_O}, {24'b0, q_stb.pop_front()});
    end
    if (o_load) begin
      if (q_load.size() == 0) chk("load_extra", {31'b0, o_load}, 32'd0);
      else                    chk("o_mask", {24'b0, o_mask}, {24'b0, q_load.pop_front()});
    end
  end

  initial begin
    RST_I = 1'b1; STB_I = 1'b0; DAT_I = 8'h00; i_button = 1'b0; i_dip_n = 8'hFF;
    tick(3);
    chk("rst_stb", {31'b0, STB_O}, 32'd0);
    chk("rst_dat", {24'b0, DAT_O}, 32'd0);
    chk("rst_mask", {24'b0, o_mask}, 32'd0);
    chk("rst_load", {31'b0, o_load}, 32'd0);
    chk("rst_alive", {31'b0, o_alive}, 32'd0);
    RST_I = 1'b0;
    tick(50);
    chk("idle_mask", {24'b0, o_mask}, 32'd0);
    fetch(8'h01);

    // First press captures A5.
    i_dip_n = 8'h5A; i_button = 1'b1;
    q_load.push_back(8'hA5);
    tick(DEB + 5);
    chk("press1_q", q_load.size(), 0);
    tick(100);
    chk("press1_mask", {24'b0, o_mask}, 32'hA5);

    // Release, then a glitch too short to debounce.
    i_button = 1'b0;
    tick(DEB + 5);
    i_button = 1'b1;
    tick(DEB - 2);
    i_button = 1'b0;
    tick(30);
    fetch(8'hFF);

    // Press with dip0 on; reported bits shift up by one.
    i_dip_n = 8'hFE; i_button = 1'b1;
    q_load.push_back(8'h01);
    tick(DEB + 5);
    fetch(8'h01);
    fetch(8'h02);
    fetch_hold(8'h03, 3, 1);
    fetch_hold(8'h03, 4, 2);

    // DIP changes alone leave the mask alone; a new press picks them up.
    i_dip_n = 8'h00;
    tick(DEB + 5);
    chk("dip_only_mask", {24'b0, o_mask}, 32'h01);
    i_button = 1'b0;
    tick(DEB + 5);
    i_button = 1'b1;
    q_load.push_back(8'hFF);
    tick(DEB + 5);
    chk("press3_mask", {24'b0, o_mask}, 32'hFF);

    // Async reset while in SAMPLE with the button still held.
    STB_I = 1'b1; DAT_I = 8'hFF;
    tick(1);
    STB_I = 1'b0;
    #1 RST_I = 1'b1;
    #1;
    chk("mid_rst_stb", {31'b0, STB_O}, 32'd0);
    chk("mid_rst_dat", {24'b0, DAT_O}, 32'd0);
    chk("mid_rst_mask", {24'b0, o_mask}, 32'd0);
    chk("mid_rst_load", {31'b0, o_load}, 32'd0);
    chk("mid_rst_alive", {31'b0, o_alive}, 32'd0);
    tick(2);
    // Button still held across reset, so it re-debounces as a press.
    q_load.push_back(8'hFF);
    RST_I = 1'b0;
    tick(DEB + 10);
    chk("post_rst_q", q_load.size(), 0);

    i_button = 1'b0; i_dip_n = 8'h3C;
    tick(DEB + 5);
    i_button = 1'b1;
    q_load.push_back(8'hC3);
    tick(DEB + 5);
    chk("press4_mask", {24'b0, o_mask}, 32'hC3);
    fetch(8'hFF);

    tick(5);
    chk("stb_left", q_stb.size(), 0);
    chk("load_left", q_load.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
